// File: rtl/vic_responder_if.sv
// vic_responder_if: CPU <-> interrupt responder vector handshake.
//
// Handshake: the CPU (master) raises istb to read a vector and holds it
// until it sees iack. The responder (slave) drives ivec together with
// iack and holds both stable while istb stays high. Dropping istb
// closes the transfer, and the responder then clears iack and ivec.
// A strobe dropped before iack ever rises is an aborted read: nothing
// is acknowledged. virq is a level request from the responder to the CPU.
interface vic_responder_if;
  logic        virq;
  logic        istb;
  logic [15:0] ivec;
  logic        iack;

  modport slave (
    output virq,
    output ivec,
    output iack,
    input  istb
  );

  modport master (
    input  virq,
    input  ivec,
    input  iack,
    output istb
  );
endinterface

// File: rtl/vic_responder.sv
// vic_responder: vectored interrupt responder.
// Collects level requests from N peripheral channels and raises virq.
// On a CPU vector-read strobe it arbitrates, returns the winner's vector
// with iack, and pulses that channel's dev_ack for exactly one cycle.
// Optional build macro VIC_ROTATE_PRIO_EN selects round-robin
// arbitration. Without it, priority is fixed and bit 0 is highest.
module vic_responder #(
  parameter int         N        = 8,
  parameter logic [8:0] SPUR_VEC = 9'o000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [N-1:0]     dev_irq,
  input  logic [9*N-1:0]   dev_vec,
  output logic [N-1:0]     dev_ack,
  vic_responder_if.slave   bus,
  output logic [1:0]       state_dbg
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            virq_q, virq_nxt;
  logic            iack_q, iack_nxt;
  logic [15:0]     ivec_q, ivec_nxt;
  logic [N-1:0]    dev_ack_q, dev_ack_nxt;
  logic [IW-1:0]   win_idx, win_idx_nxt;
  logic            win_vld, win_vld_nxt;
  logic [IW-1:0]   arb_idx;
  logic [8:0]      sel_vec;
`ifdef VIC_ROTATE_PRIO_EN
  logic [IW-1:0]   rp, rp_nxt;
`endif

  // Bits [1:0] of any vector are forced to zero on the bus.
  function automatic logic [15:0] fmt_vec(input logic [8:0] v);
    fmt_vec = {7'b0, v & 9'b111111100};
  endfunction

  // Arbiter: pick the winning request index for the current dev_irq.
  always_comb begin : arb
`ifdef VIC_ROTATE_PRIO_EN
    int  k;
    logic found;
    k       = 0;
    found   = 1'b0;
    arb_idx = '0;
    // Search upward from the rotating pointer with wrap-around.
    for (int off = 0; off < N; off++) begin
      k = int'(rp) + off;
      if (k >= N) k = k - N;
      if (!found && dev_irq[k]) begin
        found   = 1'b1;
        arb_idx = IW'(k);
      end
    end
`else
    arb_idx = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (dev_irq[i]) arb_idx = IW'(i);
    end
`endif
  end

  // Vector mux: the captured winner's 9-bit vector.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IW'(i)) sel_vec = dev_vec[9*i +: 9];
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt   = state;
    virq_nxt    = virq_q;
    iack_nxt    = iack_q;
    ivec_nxt    = ivec_q;
    dev_ack_nxt = '0;
    win_idx_nxt = win_idx;
    win_vld_nxt = win_vld;
`ifdef VIC_ROTATE_PRIO_EN
    rp_nxt      = rp;
`endif
    case (state)
      IDLE: begin
        virq_nxt = |dev_irq;
        if (bus.istb) begin
          // Capture the winner now; later request changes do not alter it.
          win_idx_nxt = arb_idx;
          win_vld_nxt = |dev_irq;
          state_nxt   = LATCH;
        end
      end
      LATCH: begin
        // Hold virq low so the serviced device has time to drop its request.
        virq_nxt = 1'b0;
        if (bus.istb) begin
          ivec_nxt = win_vld ? fmt_vec(sel_vec) : fmt_vec(SPUR_VEC);
          iack_nxt = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (win_idx == IW'(i)) dev_ack_nxt[i] = win_vld;
          end
`ifdef VIC_ROTATE_PRIO_EN
          if (win_vld) rp_nxt = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
`endif
          state_nxt = ACK;
        end else begin
          // Aborted read: nothing is acknowledged.
          ivec_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      ACK: begin
        virq_nxt = 1'b0;
        if (!bus.istb) begin
          iack_nxt  = 1'b0;
          ivec_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output and capture registers, cleared asynchronously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      virq_q    <= 1'b0;
      iack_q    <= 1'b0;
      ivec_q    <= '0;
      dev_ack_q <= '0;
      win_idx   <= '0;
      win_vld   <= 1'b0;
    end else begin
      virq_q    <= virq_nxt;
      iack_q    <= iack_nxt;
      ivec_q    <= ivec_nxt;
      dev_ack_q <= dev_ack_nxt;
      win_idx   <= win_idx_nxt;
      win_vld   <= win_vld_nxt;
    end
  end

`ifdef VIC_ROTATE_PRIO_EN
  // Round-robin pointer, advanced only by serviced acknowledges.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) rp <= '0;
    else          rp <= rp_nxt;
  end
`endif

  assign bus.virq  = virq_q;
  assign bus.iack  = iack_q;
  assign bus.ivec  = ivec_q;
  assign dev_ack   = dev_ack_q;
  assign state_dbg = state;

endmodule
